// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver that writes each frame of BYTES bytes into slot s of a frame buffer.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around its centre instead of one sample.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter int BYTES      = 14,
    parameter int SLOTS      = 32,
    parameter int TIMEOUT    = 320
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       frame_done,
    output logic       frame_err,
    output logic [4:0] slot,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_P = OVERSAMPLE / 2;
`else
    localparam int START_P = OVERSAMPLE / 2 - 1;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          rx_m_q, rx_s_q, sample;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, wr_data_q, wr_data_d;
    logic [4:0]    byte_idx_q, byte_idx_d, slot_q, slot_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [8:0]    wr_addr_q, wr_addr_d;
    logic          wr_en_q, wr_en_d, frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d, busy_q, busy_d;

`ifdef UART_RX_MAJORITY_EN
    logic h1_q, h2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            h1_q <= 1'b1;
            h2_q <= 1'b1;
        end else begin
            h1_q <= rx_s_q;
            h2_q <= h1_q;
        end
    end
    // The vote is taken one tick late, so it covers the nominal sample tick and both neighbours.
    assign sample = (rx_s_q & h1_q) | (rx_s_q & h2_q) | (h1_q & h2_q);
`else
    assign sample = rx_s_q;
`endif

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        slot_d       = slot_q;
        idle_d       = '0;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end else if (byte_idx_q != 5'd0) begin
                    if (idle_q == IW'(TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            START: if (tick_q == TW'(START_P)) begin
                tick_d    = '0;
                bit_cnt_d = '0;
                state_d   = sample ? IDLE : DATA;
            end
            DATA: if (tick_q == TW'(OVERSAMPLE - 1)) begin
                tick_d    = '0;
                shift_d   = {sample, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) state_d = STOP;
            end
            STOP: if (tick_q == TW'(OVERSAMPLE - 1)) begin
                tick_d = '0;
                if (sample) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = shift_q;
                    wr_addr_d = 9'(byte_idx_q) + 9'(slot_q) * 9'(BYTES);
                    state_d   = IDLE;
                    if (byte_idx_q == 5'(BYTES - 1)) begin
                        frame_done_d = 1'b1;
                        byte_idx_d   = '0;
                        slot_d       = (slot_q == 5'(SLOTS - 1)) ? 5'd0 : slot_q + 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    byte_idx_d  = '0;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                tick_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d inside {START, DATA, STOP};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            slot_q       <= '0;
            idle_q       <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            rx_m_q       <= rx;
            rx_s_q       <= rx_m_q;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            slot_q       <= slot_d;
            idle_q       <= idle_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign slot       = slot_q;
    assign busy       = busy_q;
endmodule
